// File: rtl/layer_lut_seq_pkg.sv
// Shared definitions for the sequential LUT-layer evaluator.
// Holds the FSM state type, the configuration-select encodings, the default
// neuron fan-in and a small width helper used by every file of the block.
package layer_lut_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic CFG_SEL_TT    = 1'b0;
  localparam logic CFG_SEL_FANIN = 1'b1;

  localparam int FANIN_DEF = 6;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_lut_seq_if.sv
// Handshake and configuration bus of layer_lut_seq.
//   in_valid/in_ready/in_vec     : input vector handshake
//   out_valid/out_ready/out_vec  : result handshake
//   cfg_we/cfg_sel/cfg_neur/cfg_data/cfg_ready : configuration write port
// master = stimulus side, slave = the evaluator.
interface layer_lut_seq_if import layer_lut_seq_pkg::*; #(
  parameter int IN_W   = 16,
  parameter int N_NEUR = 16,
  parameter int FANIN  = FANIN_DEF
);

  localparam int TT_W = 2 ** FANIN;
  localparam int NW   = idx_w(N_NEUR);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_vec;

  logic              out_valid;
  logic              out_ready;
  logic [N_NEUR-1:0] out_vec;

  logic              cfg_we;
  logic              cfg_sel;
  logic [NW-1:0]     cfg_neur;
  logic [TT_W-1:0]   cfg_data;
  logic              cfg_ready;

  modport master (
    output in_valid, in_vec, out_ready, cfg_we, cfg_sel, cfg_neur, cfg_data,
    input  in_ready, out_valid, out_vec, cfg_ready
  );

  modport slave (
    input  in_valid, in_vec, out_ready, cfg_we, cfg_sel, cfg_neur, cfg_data,
    output in_ready, out_valid, out_vec, cfg_ready
  );

endinterface

// File: rtl/layer_lut_bank.sv
// Truth-table and fan-in storage for all neurons plus the combinational
// lookup of one neuron against the registered input vector.
// Ports:
//   clk                         : write clock
//   cfg_wr/cfg_sel/cfg_neur/cfg_data : qualified configuration write
//   n                           : neuron being evaluated
//   vec                         : registered input vector
//   lut_bit                     : tt[n][address built from vec and fanin[n]]
// Storage is deliberately not reset so tables survive rst_n.
module layer_lut_bank import layer_lut_seq_pkg::*; #(
  parameter  int IN_W   = 16,
  parameter  int N_NEUR = 16,
  parameter  int FANIN  = FANIN_DEF,
  localparam int TT_W   = 2 ** FANIN,
  localparam int NW     = idx_w(N_NEUR),
  localparam int IDX_W  = idx_w(IN_W),
  localparam int FM_W   = FANIN * IDX_W
) (
  input  logic            clk,
  input  logic            cfg_wr,
  input  logic            cfg_sel,
  input  logic [NW-1:0]   cfg_neur,
  input  logic [TT_W-1:0] cfg_data,
  input  logic [NW-1:0]   n,
  input  logic [IN_W-1:0] vec,
  output logic            lut_bit
);

  (* rom_style = "distributed" *) logic [TT_W-1:0] tt_mem  [N_NEUR];
  (* rom_style = "distributed" *) logic [FM_W-1:0] fan_mem [N_NEUR];

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      if (cfg_sel == CFG_SEL_TT) tt_mem[cfg_neur]  <= cfg_data;
      else                       fan_mem[cfg_neur] <= cfg_data[FM_W-1:0];
    end
  end

  // The vector is zero-extended to the full index range so that any fan-in
  // index at or beyond IN_W naturally reads as 0.
  logic [2**IDX_W-1:0] vec_ext;
  logic [FM_W-1:0]     fmap;
  logic [FANIN-1:0]    addr;

  always_comb begin
    vec_ext           = '0;
    vec_ext[IN_W-1:0] = vec;
    fmap              = fan_mem[n];
    addr              = '0;
    for (int k = 0; k < FANIN; k++) begin
      addr[k] = vec_ext[fmap[k*IDX_W +: IDX_W]];
    end
    lut_bit = tt_mem[n][addr];
  end

endmodule

// File: rtl/layer_lut_seq.sv
// Sequential LUT-layer evaluator: accepts an IN_W-bit vector, evaluates
// N_NEUR lookup-table neurons one per cycle and presents the N_NEUR-bit
// result with a valid/ready handshake.
// Ports:
//   clk, rst_n (synchronous, active low)
//   bus      : layer_lut_seq_if.slave (input, result and config handshakes)
//   perf_cnt : completed-vector count
// Build option: LAYER_LUT_SEQ_PERF_EN enables perf_cnt; otherwise it is 0.
//
// state | meaning
// IDLE  | waiting; config writes accepted, cfg_we blocks vector acceptance
// RUN   | evaluating neuron n, one per cycle
// DONE  | result valid, held until out_ready
module layer_lut_seq import layer_lut_seq_pkg::*; #(
  parameter int IN_W   = 16,
  parameter int N_NEUR = 16,
  parameter int FANIN  = FANIN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  layer_lut_seq_if.slave bus,
  output logic [31:0] perf_cnt
);

  localparam int NW = idx_w(N_NEUR);

  state_e            state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [IN_W-1:0]   vec_q, vec_d;
  logic [N_NEUR-1:0] res_q, res_d;

  logic in_rdy;
  logic cfg_rdy;
  logic cfg_wr;
  logic lut_bit;

  layer_lut_bank #(
    .IN_W   (IN_W),
    .N_NEUR (N_NEUR),
    .FANIN  (FANIN)
  ) u_bank (
    .clk      (clk),
    .cfg_wr   (cfg_wr),
    .cfg_sel  (bus.cfg_sel),
    .cfg_neur (bus.cfg_neur),
    .cfg_data (bus.cfg_data),
    .n        (n_q),
    .vec      (vec_q),
    .lut_bit  (lut_bit)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    vec_d   = vec_q;
    res_d   = res_q;

    in_rdy  = ((state_q == IDLE) && !bus.cfg_we) ||
              ((state_q == DONE) && bus.out_ready);
    cfg_rdy = (state_q == IDLE);
    cfg_wr  = bus.cfg_we && cfg_rdy;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_rdy) begin
          vec_d   = bus.in_vec;
          n_d     = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[n_q] = lut_bit;
        if (n_q == NW'(N_NEUR - 1)) begin
          n_d     = '0;
          state_d = DONE;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            vec_d   = bus.in_vec;
            n_d     = '0;
            res_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      vec_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.cfg_ready = cfg_rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_vec   = res_q;

`ifdef LAYER_LUT_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == DONE) && bus.out_ready) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_layer_lut_seq.sv
module tb_layer_lut_seq;
  import layer_lut_seq_pkg::*;

  localparam int IN_W   = 16;
  localparam int N_NEUR = 16;
  localparam int FANIN  = 6;
  localparam int TT_W   = 64;
  localparam int LAT    = N_NEUR + 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] perf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what each neuron should compute.
  logic [TT_W-1:0] tt_m  [N_NEUR];
  int              fan_m [N_NEUR][FANIN];
  logic [31:0]     perf_exp = 0;

  layer_lut_seq_if #(.IN_W(IN_W), .N_NEUR(N_NEUR), .FANIN(FANIN)) bus ();

  layer_lut_seq #(.IN_W(IN_W), .N_NEUR(N_NEUR), .FANIN(FANIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .perf_cnt (perf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each neuron: address bit k is the vector bit selected by its k-th fanin
  // (0 when out of range); the output is that bit of its truth table.
  function automatic logic [N_NEUR-1:0] model(input logic [IN_W-1:0] v);
    logic [N_NEUR-1:0] r;
    r = '0;
    for (int i = 0; i < N_NEUR; i++) begin
      int a;
      a = 0;
      for (int k = 0; k < FANIN; k++) begin
        if (fan_m[i][k] < IN_W && v[fan_m[i][k]]) a += (1 << k);
      end
      r[i] = tt_m[i][a];
    end
    return r;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic cfg_tt(input int i, input logic [63:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = CFG_SEL_TT;
    bus.cfg_neur = i[3:0];
    bus.cfg_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    tt_m[i] = d;
  endtask

  task automatic cfg_fan(input int i, input logic [23:0] p);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = CFG_SEL_FANIN;
    bus.cfg_neur = i[3:0];
    bus.cfg_data = {40'h0, p};
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    for (int k = 0; k < FANIN; k++) fan_m[i][k] = int'(p[k*4 +: 4]);
  endtask

  task automatic accept(input logic [IN_W-1:0] v);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    #1;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // start: number of falling edges already seen since the acceptance edge.
  task automatic wait_out(input string tag, input int start, input logic [N_NEUR-1:0] exp);
    int cyc;
    cyc = start;
    while (!bus.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_out_vec"}, bus.out_vec, exp);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
`ifdef LAYER_LUT_SEQ_PERF_EN
    perf_exp = perf_exp + 32'd1;
`endif
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [IN_W-1:0] v);
    accept(v);
    wait_out(tag, 1, model(v));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    release_out();
    check({tag, "_perf"}, perf_cnt, perf_exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0]   v;
    logic [N_NEUR-1:0] hold;
    logic [63:0]       old_tt;
    bit                seen;

    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = 1'b0;
    bus.cfg_neur  = '0;
    bus.cfg_data  = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_vec", bus.out_vec, 0);
    check("rst_perf", perf_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity: neuron i looks only at bit i, table true only at all-ones.
    for (int i = 0; i < N_NEUR; i++) begin
      v = IN_W'(i);
      cfg_tt(i, 64'h8000_0000_0000_0000);
      cfg_fan(i, {6{v[3:0]}});
    end
    accept(16'hA5C3);
    wait_out("ident", 1, 16'hA5C3);
    check("ident_model", model(16'hA5C3), bus.out_vec);
    release_out();

    // Inverted bit: neuron 0 is a 6-input NOR of bits 0..5.
    cfg_tt(0, 64'h1);
    cfg_fan(0, 24'h543210);
    for (int i = 1; i < N_NEUR; i++) cfg_tt(i, 64'h0);
    accept(16'h0000);
    wait_out("inv0", 1, 16'h0001);
    release_out();
    accept(16'h0001);
    wait_out("inv1", 1, 16'h0000);
    release_out();

    // Random tables and fanins, random vectors.
    for (int i = 0; i < N_NEUR; i++) begin
      cfg_tt(i, {$urandom, $urandom});
      cfg_fan(i, 24'($urandom));
    end
    for (int t = 0; t < 20; t++) run_vec("rand", 16'($urandom));

    // Backpressure, then back-to-back acceptance on the out_ready pulse.
    accept(16'($urandom));
    wait_out("bp", 1, model(dut.vec_q));
    hold = bus.out_vec;
    v = 16'($urandom);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_stable", bus.out_vec, hold);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", bus.in_ready, 1);
    @(posedge clk);
`ifdef LAYER_LUT_SEQ_PERF_EN
    perf_exp = perf_exp + 32'd1;
`endif
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    wait_out("b2b", 1, model(v));
    release_out();

    // Config write wins over a simultaneous vector; RUN-time writes ignored.
    old_tt = tt_m[3];
    v = 16'($urandom);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = CFG_SEL_TT;
    bus.cfg_neur = 4'd3;
    bus.cfg_data = ~old_tt;
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    #1;
    check("prio_in_ready", bus.in_ready, 0);
    check("prio_cfg_ready", bus.cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    tt_m[3] = ~old_tt;
    #1;
    check("prio_next_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_data = old_tt;
    #1;
    check("run_cfg_ready", bus.cfg_ready, 0);
    repeat (3) @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_out("prio", 4, model(v));
    release_out();
    run_vec("after_run_cfg", ~v);

    // Reset in the middle of RUN.
    accept(16'($urandom));
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    perf_exp = 0;
    check("mrst_in_ready", bus.in_ready, 1);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_perf", perf_cnt, 0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("mrst_no_output", seen, 0);
    for (int t = 0; t < 3; t++) run_vec("post_rst", 16'($urandom));

`ifdef LAYER_LUT_SEQ_PERF_EN
    check("perf_three", perf_cnt, 32'd3);
    force dut.perf_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.perf_q;
    perf_exp = 32'hFFFF_FFFF;
    run_vec("wrap", 16'($urandom));
    check("perf_wrap", perf_cnt, 32'd0);
`else
    check("perf_tied", perf_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
